// File: rtl/sobel_vga_out.sv
// sobel_vga_out: pixel sink for the Sobel output stream.
// Buffers incoming pixels in a FIFO. Generates SVGA raster timing and scans the buffered
// image out, centred in a fixed window.
// Optional build macro SOBEL_VGA_TESTPAT_EN adds TP_SEL_I. When TP_SEL_I is high, window
// pixels show h_cnt ^ v_cnt instead of FIFO data.
module sobel_vga_out #(
    parameter int unsigned IMG_W      = 538,
    parameter int unsigned IMG_H      = 538,
    parameter int unsigned H_ACT      = 800,
    parameter int unsigned H_FP       = 40,
    parameter int unsigned H_SYNC     = 128,
    parameter int unsigned H_BP       = 88,
    parameter int unsigned V_ACT      = 600,
    parameter int unsigned V_FP       = 1,
    parameter int unsigned V_SYNC     = 4,
    parameter int unsigned V_BP       = 23,
    parameter int unsigned H_OFF      = 131,
    parameter int unsigned V_OFF      = 31,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned PREFILL    = 512,
    parameter bit          SYNC_POL   = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] PIXEL_I,
    input  logic       PIXEL_EN_I,
    input  logic       START_I,
`ifdef SOBEL_VGA_TESTPAT_EN
    input  logic       TP_SEL_I,
`endif
    output logic [7:0] GRAY_O,
    output logic       HSYNC_O,
    output logic       VSYNC_O,
    output logic       DE_O,
    output logic       FRAME_DONE_O,
    output logic       OVERFLOW_O,
    output logic       UNDERFLOW_O
);

    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned PW    = $clog2(NPIX);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_E  = HW'(H_ACT);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_WIN_S  = HW'(H_OFF);
    localparam logic [HW-1:0] H_WIN_E  = HW'(H_OFF + IMG_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACT);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_WIN_S  = VW'(V_OFF);
    localparam logic [VW-1:0] V_WIN_E  = VW'(V_OFF + IMG_H);
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_PRE  = (AW + 1)'(PREFILL);

    typedef enum logic [1:0] {StIdle, StArmed, StActive} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt_q;
    logic [VW-1:0]   v_cnt_q;
    logic [PW-1:0]   pix_cnt_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q, level;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [7:0]      gray_d;
    logic            h_wrap, v_wrap, active_rgn, in_win, win_px, fifo_px, last_px;
    logic            fifo_full, fifo_empty, push, pop, last_q;

    assign h_wrap     = (h_cnt_q == H_LAST);
    assign v_wrap     = (v_cnt_q == V_LAST);
    assign active_rgn = (h_cnt_q < H_ACT_E) && (v_cnt_q < V_ACT_E);
    assign in_win     = (h_cnt_q >= H_WIN_S) && (h_cnt_q < H_WIN_E) &&
                        (v_cnt_q >= V_WIN_S) && (v_cnt_q < V_WIN_E);
    assign win_px     = (state_q == StActive) && in_win && active_rgn;
    assign last_px    = win_px && (pix_cnt_q == PIX_LAST);

`ifdef SOBEL_VGA_TESTPAT_EN
    logic [7:0] tp_pix;
    assign tp_pix  = 8'(h_cnt_q) ^ 8'(v_cnt_q);
    assign fifo_px = win_px && !TP_SEL_I;
`else
    assign fifo_px = win_px;
`endif

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);
    assign pop        = fifo_px && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    assign push       = PIXEL_EN_I && (!fifo_full || pop);

    // Free-running raster counters, independent of display state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (h_wrap) begin
            h_cnt_q <= '0;
            v_cnt_q <= v_wrap ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_q <= h_cnt_q + HW'(1);
        end
    end

    // FIFO storage; contents are not reset, the pointers alone define what is valid
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= PIXEL_I;
    end

    // FIFO pointers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    // Display state register and window pixel counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            pix_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != StActive) pix_cnt_q <= '0;
            else if (win_px)         pix_cnt_q <= pix_cnt_q + PW'(1);
        end
    end

    // Next-state logic; a frame may only begin at raster origin with enough data buffered
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (START_I) state_d = StArmed;
            StArmed:  if ((h_cnt_q == '0) && (v_cnt_q == '0) && (level >= LVL_PRE))
                          state_d = StActive;
            StActive: if (last_px) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Pixel value for the current raster position; zero outside the window or on underflow
    always_comb begin
        gray_d = 8'h00;
        if (pop) gray_d = mem[rd_ptr_q[AW-1:0]];
`ifdef SOBEL_VGA_TESTPAT_EN
        if (win_px && TP_SEL_I) gray_d = tp_pix;
`endif
    end

    // Registered outputs; all share one cycle of latency from the counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GRAY_O       <= 8'h00;
            DE_O         <= 1'b0;
            HSYNC_O      <= ~SYNC_POL;
            VSYNC_O      <= ~SYNC_POL;
            last_q       <= 1'b0;
            FRAME_DONE_O <= 1'b0;
            OVERFLOW_O   <= 1'b0;
            UNDERFLOW_O  <= 1'b0;
        end else begin
            GRAY_O       <= gray_d;
            DE_O         <= active_rgn;
            HSYNC_O      <= ((h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
            VSYNC_O      <= ((v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
            // Done follows the cycle in which the last pixel appears on GRAY_O
            last_q       <= last_px;
            FRAME_DONE_O <= last_q;
            OVERFLOW_O   <= OVERFLOW_O | (PIXEL_EN_I && fifo_full && !pop);
            UNDERFLOW_O  <= UNDERFLOW_O | (fifo_px && fifo_empty);
        end
    end

endmodule

// File: tb/tb_sobel_vga_out.sv
// Bench for sobel_vga_out, run with a scaled-down raster so whole frames fit in a short run.
// Raster is 24 x 17 clocks with a 16 x 12 active area. The image is 6 x 5 at offset (3,2).
// The FIFO is 16 deep with a prefill level of 8.
module tb_sobel_vga_out;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int IW = 6, IH = 5, HO = 3, VO = 2, DEPTH = 16, PRE = 8;
    localparam int FRAME = HT * VT;
    localparam int M_IDLE = 0, M_ARMED = 1, M_ACTIVE = 2;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] pix = 8'h00;
    logic       en = 1'b0, start = 1'b0;
`ifdef SOBEL_VGA_TESTPAT_EN
    logic       tp_sel = 1'b0;
`endif
    logic [7:0] gray;
    logic       hs, vs, de, done, ovf, unf;

    always #5 clk = ~clk;

    sobel_vga_out #(
        .IMG_W(IW), .IMG_H(IH), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_OFF(HO), .V_OFF(VO),
        .FIFO_DEPTH(DEPTH), .PREFILL(PRE), .SYNC_POL(1'b1)
    ) dut (
        .CLK(clk), .RST(rst), .PIXEL_I(pix), .PIXEL_EN_I(en), .START_I(start),
`ifdef SOBEL_VGA_TESTPAT_EN
        .TP_SEL_I(tp_sel),
`endif
        .GRAY_O(gray), .HSYNC_O(hs), .VSYNC_O(vs), .DE_O(de),
        .FRAME_DONE_O(done), .OVERFLOW_O(ovf), .UNDERFLOW_O(unf)
    );

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raster position from elapsed cycles, FIFO as a queue
    byte unsigned m_q[$];
    int  m_t = 0, m_mode = M_IDLE, m_n = 0;
    bit  m_pend = 0, m_ovf = 0, m_unf = 0;
    int  e_gray = 0, e_de = 0, e_hs = 0, e_vs = 0, e_done = 0;
    int  p = 0, h = 0, v = 0, sz = 0;
    bit  inwin, popped;
    // Tallies of observed DUT behaviour, used by the literal checks
    int  de_cnt = 0, hs_cnt = 0, vs_cnt = 0, first_hs = -1, first_vs = -1;
    int  done_cnt = 0, done_h = -1, done_v = -1;
    logic [7:0] cap [FRAME];

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_t = 0; m_mode = M_IDLE; m_n = 0; m_pend = 0; m_ovf = 0; m_unf = 0;
            e_gray = 0; e_de = 0; e_hs = 0; e_vs = 0; e_done = 0;
            de_cnt = 0; hs_cnt = 0; vs_cnt = 0; first_hs = -1; first_vs = -1;
            done_cnt = 0; done_h = -1; done_v = -1;
        end else begin
            p = m_t; h = p % HT; v = (p / HT) % VT;
            e_de   = (h < HA) && (v < VA);
            e_hs   = (h >= HA + HF) && (h < HA + HF + HS);
            e_vs   = (v >= VA + VF) && (v < VA + VF + VS);
            e_gray = 0;
            e_done = m_pend;
            m_pend = 0;
            inwin  = (h >= HO) && (h < HO + IW) && (v >= VO) && (v < VO + IH);
            sz     = m_q.size();
            popped = 0;
            case (m_mode)
                M_IDLE:  if (start) m_mode = M_ARMED;
                M_ARMED: if (h == 0 && v == 0 && sz >= PRE) begin
                    m_mode = M_ACTIVE;
                    m_n = 0;
                end
                default: if (inwin) begin
                    if (sz > 0) begin
                        e_gray = m_q.pop_front();
                        popped = 1;
                    end else begin
                        m_unf = 1;
                    end
                    m_n++;
                    if (m_n == IW * IH) begin
                        m_pend = 1;
                        m_mode = M_IDLE;
                    end
                end
            endcase
            if (en) begin
                if (sz < DEPTH || popped) m_q.push_back(pix);
                else m_ovf = 1;
            end
            m_t++;
        end
        #2;
        chk("gray", int'(gray), e_gray);
        chk("de", int'(de), e_de);
        chk("hsync", int'(hs), e_hs);
        chk("vsync", int'(vs), e_vs);
        chk("frame_done", int'(done), e_done);
        chk("overflow", int'(ovf), int'(m_ovf));
        chk("underflow", int'(unf), int'(m_unf));
        if (!rst) begin
            if (de) de_cnt++;
            if (hs) begin hs_cnt++; if (first_hs < 0) first_hs = p + 1; end
            if (vs) begin vs_cnt++; if (first_vs < 0) first_vs = p + 1; end
            if (done) begin done_cnt++; done_h = h; done_v = v; end
            cap[p % FRAME] = gray;
        end
    end

    // Feed pixels while keeping the FIFO below 12 entries; return once FRAME_DONE_O is seen
    task automatic stream(input int total, input int base, output bit ok);
        int sent = 0;
        int d0 = done_cnt;
        ok = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (sent < total && m_q.size() < 12) begin
                en = 1'b1;
                pix = 8'(base + sent);
                sent++;
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
            if (done_cnt != d0) begin ok = 1; break; end
        end
        en = 1'b0;
    endtask

    task automatic push_burst(input int count, input int base);
        for (int i = 0; i < count; i++) begin
            en = 1'b1;
            pix = 8'(base + i);
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog expired");
    end

    bit ok;
    int d_before;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gray", int'(gray), 0);
        chk("rst_hsync", int'(hs), 0);
        chk("rst_vsync", int'(vs), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        // Two idle frames of raster timing
        repeat (2 * FRAME) @(negedge clk);
        chk("de_count_2frames", de_cnt, 2 * 16 * 12);     // 384
        chk("hs_count_2frames", hs_cnt, 2 * 17 * 3);      // 102
        chk("vs_count_2frames", vs_cnt, 2 * 2 * 24);      // 96
        chk("first_hs_cycle", first_hs, 19);              // h=18 plus one cycle latency
        chk("first_vs_cycle", first_vs, 13 * 24 + 1);     // 313

        // Full frame, pixel n = n
        pulse_start();
        stream(30, 0, ok);
        chk("full_done_seen", int'(ok), 1);
        chk("full_done_h", done_h, 9);
        chk("full_done_v", done_v, 6);
        chk("full_first_px1", int'(cap[2 * 24 + 4]), 1);
        chk("full_last_px", int'(cap[6 * 24 + 8]), 29);
        chk("full_unf", int'(unf), 0);
        chk("full_ovf", int'(ovf), 0);

        // Prefill gate: 5 pixels are not enough to start
        push_burst(5, 40);
        pulse_start();
        d_before = done_cnt;
        repeat (FRAME) @(negedge clk);
        chk("gate_no_done", done_cnt, d_before);
        chk("gate_blank_px1", int'(cap[2 * 24 + 4]), 0);
        stream(25, 45, ok);
        chk("gate_done_seen", int'(ok), 1);
        chk("gate_px1", int'(cap[2 * 24 + 4]), 41);
        chk("gate_last_px", int'(cap[6 * 24 + 8]), 69);
        chk("gate_unf", int'(unf), 0);

        // Underflow: only 12 pixels available
        push_burst(12, 200);
        pulse_start();
        stream(0, 0, ok);
        chk("unf_done_seen", int'(ok), 1);
        chk("unf_px11", int'(cap[3 * 24 + 8]), 211);
        chk("unf_px12_zero", int'(cap[4 * 24 + 3]), 0);
        chk("unf_flag", int'(unf), 1);
        chk("unf_ovf", int'(ovf), 0);
        chk("unf_done_h", done_h, 9);

        // Overflow: 20 pushes into a 16-entry FIFO while idle
        push_burst(20, 100);
        chk("ovf_flag", int'(ovf), 1);
        chk("ovf_model_depth", m_q.size(), 16);
        pulse_start();
        stream(0, 0, ok);
        chk("ovf_done_seen", int'(ok), 1);
        chk("ovf_px0", int'(cap[2 * 24 + 3]), 100);
        chk("ovf_px15", int'(cap[4 * 24 + 6]), 115);
        chk("ovf_px16_zero", int'(cap[4 * 24 + 7]), 0);

        // Mid-frame reset at v=8 while DE is high
        for (int c = 0; c < 2 * FRAME && !(((m_t / HT) % VT) == 8 && (m_t % HT) == 5); c++)
            @(negedge clk);
        chk("pre_rst_de", int'(de), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_gray", int'(gray), 0);
        chk("mid_rst_de", int'(de), 0);
        chk("mid_rst_hsync", int'(hs), 0);
        chk("mid_rst_vsync", int'(vs), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_unf", int'(unf), 0);
        @(negedge clk);
        rst = 1'b0;
        push_burst(10, 7);
        repeat (FRAME) @(negedge clk);
        chk("post_rst_first_hs", first_hs, 19);
        chk("post_rst_idle_px", int'(cap[2 * 24 + 3]), 0);
        chk("post_rst_no_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
